fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer with call stack and optional hardware loop stack (enabled by FETCH_SEQ_LOOP_EN)
module fetch_seq #(
  parameter int MINSTW = 9,
  parameter int SDEPTH = 8,
  parameter int LDEPTH = 2,
  parameter int LCNTW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   cmd,
  input  logic [MINSTW-1:0]            target,
  input  logic                         cond,
  input  logic [LCNTW-1:0]             lcount,
  output logic [MINSTW-1:0]            pc,
  output logic [MINSTW-1:0]            instr_addr,
  output logic                         halted,
  output logic                         err_ovf,
  output logic                         err_unf,
  output logic [$clog2(SDEPTH+1)-1:0]  depth
);
  localparam int DW = $clog2(SDEPTH + 1);
  localparam int IW = $clog2(SDEPTH);
  localparam logic [2:0] CMD_NEXT = 3'd0, CMD_JMP = 3'd1, CMD_JZ = 3'd2, CMD_JNZ = 3'd3;
  localparam logic [2:0] CMD_CALL = 3'd4, CMD_RET = 3'd5, CMD_LOOP = 3'd6;
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state;
  logic run, c_full, c_empty, c_push, c_pop;
  logic [DW-1:0] dm1;
  logic [MINSTW-1:0] pc_inc, c_top, nxt;
  logic [MINSTW-1:0] stk [SDEPTH];
  logic loop_back, l_ovf;
  logic [MINSTW-1:0] l_start_top, loop_pc;
  assign run = state == S_RUN && !stall;
  assign halted = state == S_HALT;
  assign pc_inc = pc + MINSTW'(1);
  assign c_full = depth == DW'(SDEPTH);
  assign c_empty = depth == '0;
  assign dm1 = depth - DW'(1);
  assign c_top = stk[dm1[IW-1:0]];
  assign c_push = run && cmd == CMD_CALL && !c_full;
  assign c_pop = run && cmd == CMD_RET && !c_empty;
`ifdef FETCH_SEQ_LOOP_EN
  localparam int LW = $clog2(LDEPTH + 1);
  localparam int LIW = LDEPTH > 1 ? $clog2(LDEPTH) : 1;
  logic [LW-1:0] lsp, lm1;
  logic [MINSTW-1:0] l_start [LDEPTH];
  logic [MINSTW-1:0] l_end [LDEPTH];
  logic [LCNTW-1:0] l_cnt [LDEPTH];
  logic l_full, l_push, l_pop, loop_end;
  assign lm1 = lsp - LW'(1);
  assign l_full = lsp == LW'(LDEPTH);
  assign loop_end = cmd == CMD_NEXT && lsp != '0 && pc == l_end[lm1[LIW-1:0]];
  assign loop_back = loop_end && l_cnt[lm1[LIW-1:0]] > LCNTW'(1);
  assign l_start_top = l_start[lm1[LIW-1:0]];
  assign loop_pc = lcount == '0 ? target + MINSTW'(1) : pc_inc;
  assign l_ovf = cmd == CMD_LOOP && lcount != '0 && l_full;
  assign l_push = run && cmd == CMD_LOOP && lcount != '0 && !l_full;
  assign l_pop = run && loop_end && !loop_back;
  // loop stack pointer, cleared asynchronously so no loop survives reset
  always_ff @(posedge clk or posedge rst)
    if (rst) lsp <= '0;
    else lsp <= l_push ? lsp + LW'(1) : l_pop ? lsp - LW'(1) : lsp;
  // loop frame storage: push new frame or decrement the active count
  always_ff @(posedge clk) begin
    if (l_push) begin
      l_start[lsp[LIW-1:0]] <= pc_inc;
      l_end[lsp[LIW-1:0]] <= target;
      l_cnt[lsp[LIW-1:0]] <= lcount;
    end
    if (run && loop_back) l_cnt[lm1[LIW-1:0]] <= l_cnt[lm1[LIW-1:0]] - LCNTW'(1);
  end
`else
  localparam int unused_ldepth = LDEPTH;
  logic unused_lcount;
  assign unused_lcount = ^lcount;
  assign loop_back = 1'b0;
  assign l_start_top = pc;
  assign loop_pc = pc_inc;
  assign l_ovf = 1'b0;
`endif
  // next-pc selection; held at pc while halted or stalled
  always_comb begin
    nxt = pc_inc;
    case (cmd)
      CMD_NEXT: nxt = loop_back ? l_start_top : pc_inc;
      CMD_JMP:  nxt = target;
      CMD_JZ:   nxt = cond ? pc_inc : target;
      CMD_JNZ:  nxt = cond ? target : pc_inc;
      CMD_CALL: nxt = c_full ? pc_inc : target;
      CMD_RET:  nxt = c_empty ? pc_inc : c_top;
      CMD_LOOP: nxt = loop_pc;
      default:  nxt = pc;
    endcase
    instr_addr = run ? nxt : pc;
  end
  // run/halt state, pc, call depth and sticky error flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_RUN;
      pc <= '0;
      depth <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (run) begin
      pc <= instr_addr;
      if (cmd == 3'd7) state <= S_HALT;
      depth <= c_push ? depth + DW'(1) : c_pop ? dm1 : depth;
      if ((cmd == CMD_CALL && c_full) || l_ovf) err_ovf <= 1'b1;
      if (cmd == CMD_RET && c_empty) err_unf <= 1'b1;
    end
  // call-stack storage holds return addresses
  always_ff @(posedge clk)
    if (c_push) stk[depth[IW-1:0]] <= pc_inc;
endmodule
